// File: rtl/serial_add_seq_pkg.sv
// Package for the serial adder sequencer.
//   state_t : sequencer FSM states (IDLE, SHIFT, DRAIN, DONE)
//   cnt_w   : bit-index counter width, max(1, $clog2(w))
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    function automatic int cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_seq_if.sv
// Operand/result handshake bundle for serial_add_seq.
//   in_valid/in_ready/in_a/in_b/in_cin     : upstream operand transfer
//   out_valid/out_ready/out_sum/out_cout   : downstream result transfer
// master = producer of operands / consumer of results, slave = sequencer.
interface serial_add_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/serial_add_seq_piso.sv
// Parallel-in serial-out shift register, LSB first.
//   clk, rst_n : clock, async active-low reset (clears the register)
//   load       : capture din (has priority over shift)
//   shift      : shift right by one, zero-filling the MSB
//   din        : parallel load value
//   sout       : current LSB
module serial_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         sout
);
    logic [W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr >> 1;
        end
    end

    assign sout = sr[0];
endmodule

// File: rtl/serial_add_seq.sv
// Sequencer around a single-bit registered serial adder.
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : operand valid/ready in, result valid/ready out
//   ser_a/ser_b     : operand bits presented to the adder, LSB first
//   ser_cin         : carry presented to the adder
//   ser_sum/ser_cout: adder registered sum/carry (one-cycle latency)
//   busy            : high while in SHIFT or DRAIN
// {out_cout, out_sum} = in_a + in_b + in_cin, valid W+1 cycles after accept.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_seq_if.slave    bus,
    output logic               ser_a,
    output logic               ser_b,
    output logic               ser_cin,
    input  logic               ser_sum,
    input  logic               ser_cout,
    output logic               busy
);
    localparam int             CW       = cnt_w(W);
    localparam logic [CW-1:0]  IDX_LAST = CW'(W - 1);

    state_t        state;
    logic [CW-1:0] idx;
    logic          cin_q;
    logic [W-1:0]  res;
    logic [W-1:0]  res_shift;
    logic          out_valid_q;
    logic          out_cout_q;
    logic          accept;
    logic          in_shift;
    logic          a_bit;
    logic          b_bit;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign in_shift = (state == SHIFT);

    serial_piso #(.W(W)) u_piso_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (in_shift),
        .din   (bus.in_a),
        .sout  (a_bit)
    );

    serial_piso #(.W(W)) u_piso_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (in_shift),
        .din   (bus.in_b),
        .sout  (b_bit)
    );

    // Sum bits arrive LSB first, so they are shifted in at the MSB; after
    // exactly W captures (W-1 in SHIFT, one in DRAIN) bit 0 lands at res[0].
    assign res_shift = (res >> 1) | (W'(ser_sum) << (W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cin_q       <= 1'b0;
            res         <= '0;
            out_valid_q <= 1'b0;
            out_cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cin_q <= bus.in_cin;
                        idx   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // ser_sum only holds a valid bit from the second cycle on.
                    if (idx != '0) begin
                        res <= res_shift;
                    end
                    if (idx == IDX_LAST) begin
                        state <= DRAIN;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                DRAIN: begin
                    res         <= res_shift;
                    out_cout_q  <= ser_cout;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bit 0 takes the latched carry-in so any carry left in the adder from a
    // previous operation is never used.
    assign ser_a   = in_shift & a_bit;
    assign ser_b   = in_shift & b_bit;
    assign ser_cin = in_shift & ((idx == '0) ? cin_q : ser_cout);

    assign busy          = (state == SHIFT) || (state == DRAIN);
    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = res;
    assign bus.out_cout  = out_cout_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Testbench for serial_add_seq: W=8 instance checked through a scoreboard
// queue and monitor, plus a W=1 instance checked exhaustively. Each DUT is
// paired with a behavioural registered single-bit adder.
module tb_serial_add_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- W=8 DUT + adder ----------------
    serial_add_seq_if #(.W(W)) bus8 ();
    logic ser_a8, ser_b8, ser_cin8, ser_sum8, ser_cout8, busy8;

    serial_add_seq #(.W(W)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus8),
        .ser_a    (ser_a8),
        .ser_b    (ser_b8),
        .ser_cin  (ser_cin8),
        .ser_sum  (ser_sum8),
        .ser_cout (ser_cout8),
        .busy     (busy8)
    );

    logic adder_rst;
    assign adder_rst = ~rst_n;

    always_ff @(posedge clk or posedge adder_rst) begin
        if (adder_rst) {ser_cout8, ser_sum8} <= 2'b00;
        else           {ser_cout8, ser_sum8} <= 2'(ser_a8) + 2'(ser_b8) + 2'(ser_cin8);
    end

    // ---------------- W=1 DUT + adder ----------------
    serial_add_seq_if #(.W(1)) bus1 ();
    logic ser_a1, ser_b1, ser_cin1, ser_sum1, ser_cout1, busy1;

    serial_add_seq #(.W(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus1),
        .ser_a    (ser_a1),
        .ser_b    (ser_b1),
        .ser_cin  (ser_cin1),
        .ser_sum  (ser_sum1),
        .ser_cout (ser_cout1),
        .busy     (busy1)
    );

    always_ff @(posedge clk or posedge adder_rst) begin
        if (adder_rst) {ser_cout1, ser_sum1} <= 2'b00;
        else           {ser_cout1, ser_sum1} <= 2'(ser_a1) + 2'(ser_b1) + 2'(ser_cin1);
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        int           acc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic seen = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input int acc);
        int   total;
        exp_t e;
        total  = int'(a) + int'(b) + int'(cin);
        e.sum  = W'(total % (1 << W));
        e.cout = (total >= (1 << W));
        e.acc  = acc;
        return e;
    endfunction

    // Monitor: first cycle of out_valid checks value and latency against the
    // queue head; following cycles check that the held result stays stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (seen && !bus8.out_valid) begin
                vectors++;
                miscompares++;
                $display("FAIL valid_dropped: out_valid fell without out_ready (cycle %0d)", cyc);
                seen = 1'b0;
            end
            if (bus8.out_valid) begin
                if (!seen) begin
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_result: got sum %0h cout %0b expected no result", bus8.out_sum, bus8.out_cout);
                        cur.sum  = bus8.out_sum;
                        cur.cout = bus8.out_cout;
                    end else begin
                        cur = q.pop_front();
                        check("result_sum", 32'(bus8.out_sum), 32'(cur.sum));
                        check("result_cout", 32'(bus8.out_cout), 32'(cur.cout));
                        check("latency", 32'(cyc - cur.acc), 32'(W + 1));
                    end
                    seen = 1'b1;
                end else begin
                    check("hold_sum", 32'(bus8.out_sum), 32'(cur.sum));
                    check("hold_cout", 32'(bus8.out_cout), 32'(cur.cout));
                end
                if (bus8.out_ready) seen = 1'b0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send8(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic done;
        done = 1'b0;
        @(posedge clk); #2;
        bus8.in_valid = 1'b1;
        bus8.in_a     = a;
        bus8.in_b     = b;
        bus8.in_cin   = cin;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus8.in_ready) begin
                q.push_back(model(a, b, cin, cyc + 1));
                done = 1'b1;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready never seen, expected accept");
        end
        @(posedge clk); #2;
        bus8.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !seen && !bus8.out_valid) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", q.size());
        end
    endtask

    task automatic wait_valid8();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus8.out_valid) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL valid_timeout: out_valid 0 expected 1");
        end
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int   prev_acc;
        int   acc;
        int   n;
        int   guard;
        logic got;
        logic [W-1:0] ra, rb;
        logic         rc;

        bus8.in_valid  = 1'b0;
        bus8.in_a      = '0;
        bus8.in_b      = '0;
        bus8.in_cin    = 1'b0;
        bus8.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_a      = '0;
        bus1.in_b      = '0;
        bus1.in_cin    = 1'b0;
        bus1.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", 32'({bus8.in_ready, bus8.out_valid, bus8.out_cout, busy8,
                               ser_a8, ser_b8, ser_cin8}), 32'd0);
        check("rst_sum", 32'(bus8.out_sum), 32'd0);
        check("rst_w1", 32'({bus1.in_ready, bus1.out_valid, busy1}), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(bus8.in_ready), 32'd1);
        check("idle_busy", 32'(busy8), 32'd0);

        // Directed arithmetic
        send8(8'hA5, 8'h3C, 1'b0);
        wait_idle();
        send8(8'hFF, 8'h01, 1'b0);
        send8(8'h00, 8'h00, 1'b1);
        wait_idle();

        // Result held in DONE while out_ready is low; new operands refused
        @(posedge clk); #2;
        bus8.out_ready = 1'b0;
        send8(8'h5A, 8'hC3, 1'b1);
        wait_valid8();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            bus8.in_valid = 1'b1;
            bus8.in_a     = 8'h77;
            bus8.in_b     = 8'h11;
            @(negedge clk);
            check("done_in_ready", 32'(bus8.in_ready), 32'd0);
            check("done_valid", 32'(bus8.out_valid), 32'd1);
        end
        @(posedge clk); #2;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        wait_idle();
        repeat (15) @(negedge clk);

        // Reset in the middle of SHIFT (idx == 3)
        @(posedge clk); #2;
        bus8.in_valid = 1'b1;
        bus8.in_a     = 8'hFF;
        bus8.in_b     = 8'hFF;
        bus8.in_cin   = 1'b1;
        @(negedge clk);
        check("pre_abort_ready", 32'(bus8.in_ready), 32'd1);
        @(posedge clk); #2;
        bus8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("abort_busy_before", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_ctrl", 32'({bus8.in_ready, bus8.out_valid, bus8.out_cout, busy8,
                                 ser_a8, ser_b8, ser_cin8}), 32'd0);
        check("abort_sum", 32'(bus8.out_sum), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        send8(8'h10, 8'h20, 1'b0);
        wait_idle();

        // Back-to-back with in_valid and out_ready held high
        @(posedge clk); #2;
        bus8.in_valid = 1'b1;
        bus8.in_a     = 8'($urandom);
        bus8.in_b     = 8'($urandom);
        bus8.in_cin   = 1'($urandom);
        n        = 0;
        guard    = 0;
        prev_acc = -1;
        while (n < 6 && guard < 500) begin
            @(negedge clk);
            guard++;
            if (bus8.in_ready) begin
                acc = cyc + 1;
                q.push_back(model(bus8.in_a, bus8.in_b, bus8.in_cin, acc));
                if (prev_acc >= 0) check("b2b_spacing", 32'(acc - prev_acc), 32'(W + 3));
                prev_acc = acc;
                n++;
                @(posedge clk); #2;
                bus8.in_a   = 8'($urandom);
                bus8.in_b   = 8'($urandom);
                bus8.in_cin = 1'($urandom);
            end
        end
        if (n < 6) begin
            vectors++;
            miscompares++;
            $display("FAIL b2b_timeout: %0d accepts expected 6", n);
        end
        bus8.in_valid = 1'b0;
        wait_idle();

        // Random operands with random downstream back-pressure
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            bus8.out_ready = 1'b0;
            send8(ra, rb, rc);
            wait_valid8();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(posedge clk); #2;
            bus8.out_ready = 1'b1;
            wait_idle();
        end

        // W=1: every operand combination
        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #2;
            bus1.in_valid = 1'b1;
            bus1.in_a     = 1'(v >> 2);
            bus1.in_b     = 1'(v >> 1);
            bus1.in_cin   = 1'(v);
            got = 1'b0;
            acc = 0;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge clk);
                if (bus1.in_ready) begin
                    acc = cyc + 1;
                    got = 1'b1;
                end
            end
            @(posedge clk); #2;
            bus1.in_valid = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge clk);
                if (bus1.out_valid) got = 1'b1;
            end
            check("w1_valid", 32'(got), 32'd1);
            check("w1_latency", 32'(cyc - acc), 32'd2);
            check("w1_result", 32'({bus1.out_cout, bus1.out_sum}),
                  32'(((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1)));
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
